// File: rtl/rf_bypass_sb_if.sv
// rtl/rf_bypass_sb_if.sv - decode/writeback bus for the bypassing register file
interface rf_bypass_sb_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3
);
  logic [SEL_W-1:0] rd1_sel;
  logic [SEL_W-1:0] rd2_sel;
  logic [SEL_W-1:0] wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             pend_set_en;
  logic [SEL_W-1:0] pend_sel;
  logic [WIDTH-1:0] rd1_data;
  logic [WIDTH-1:0] rd2_data;
  logic             rd1_pend;
  logic             rd2_pend;
  logic             err;

  modport master (
    output rd1_sel, rd2_sel, wr_sel, wr_data, wr_en, pend_set_en, pend_sel,
    input  rd1_data, rd2_data, rd1_pend, rd2_pend, err
  );

  modport slave (
    input  rd1_sel, rd2_sel, wr_sel, wr_data, wr_en, pend_set_en, pend_sel,
    output rd1_data, rd2_data, rd1_pend, rd2_pend, err
  );
endinterface

// File: rtl/rf_bypass_sb.sv
// rtl/rf_bypass_sb.sv - 2R1W register file with write bypass and pending scoreboard
module rf_bypass_sb #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int SEL_W = 3
) (
  input logic           clk,
  input logic           rst,
  rf_bypass_sb_if.slave bus
);
  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] reg_en;
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_set;
  logic [NREGS-1:0] pend_next;
  logic             err;
  logic             waw;
  logic             byp1;
  logic             byp2;

  // Enables are gated before the compare so an undriven select is harmless when idle.
  always_comb begin
    reg_en   = '0;
    pend_set = '0;
    for (int i = 0; i < NREGS; i++) begin
      reg_en[i]   = bus.wr_en && (bus.wr_sel == SEL_W'(i));
      pend_set[i] = bus.pend_set_en && (bus.pend_sel == SEL_W'(i));
    end
  end

  // Set overrides the retiring write's clear; a set on a still-pending entry is a WAW.
  assign pend_next = (pend & ~reg_en) | pend_set;
  assign waw       = |(pend_set & pend & ~reg_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      pend <= '0;
      err  <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (reg_en[i]) begin
          regs[i] <= bus.wr_data;
        end
      end
      pend <= pend_next;
      if (waw) begin
        err <= 1'b1;
      end
    end
  end

  assign byp1 = bus.wr_en && (bus.wr_sel == bus.rd1_sel);
  assign byp2 = bus.wr_en && (bus.wr_sel == bus.rd2_sel);

  assign bus.rd1_data = byp1 ? bus.wr_data : regs[bus.rd1_sel];
  assign bus.rd2_data = byp2 ? bus.wr_data : regs[bus.rd2_sel];
  assign bus.rd1_pend = pend[bus.rd1_sel] && !byp1;
  assign bus.rd2_pend = pend[bus.rd2_sel] && !byp2;
  assign bus.err      = err;
endmodule

// File: tb/tb_rf_bypass_sb.sv
// tb/tb_rf_bypass_sb.sv - self-checking bench for rf_bypass_sb
module tb_rf_bypass_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rf_bypass_sb_if #(.WIDTH(16), .SEL_W(3)) bus ();

  rf_bypass_sb #(.WIDTH(16), .NREGS(8), .SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: architectural contents, pending set and error flag.
  logic [15:0] m_regs [8];
  logic        m_pend [8];
  logic        m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = 16'h0000;
        m_pend[i] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      if (bus.pend_set_en && m_pend[bus.pend_sel] &&
          !(bus.wr_en && bus.wr_sel == bus.pend_sel))
        m_err = 1'b1;
      if (bus.wr_en) begin
        m_regs[bus.wr_sel] = bus.wr_data;
        m_pend[bus.wr_sel] = 1'b0;
      end
      if (bus.pend_set_en)
        m_pend[bus.pend_sel] = 1'b1;
    end
  end

  function automatic logic [15:0] exp_data(input logic [2:0] sel);
    if (bus.wr_en && bus.wr_sel == sel) return bus.wr_data;
    return m_regs[sel];
  endfunction

  function automatic logic exp_pend(input logic [2:0] sel);
    if (bus.wr_en && bus.wr_sel == sel) return 1'b0;
    return m_pend[sel];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_rd1_data", bus.rd1_data, exp_data(bus.rd1_sel));
    check("cmp_rd2_data", bus.rd2_data, exp_data(bus.rd2_sel));
    check("cmp_rd1_pend", 16'(bus.rd1_pend), 16'(exp_pend(bus.rd1_sel)));
    check("cmp_rd2_pend", 16'(bus.rd2_pend), 16'(exp_pend(bus.rd2_sel)));
    check("cmp_err", 16'(bus.err), 16'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    bus.wr_en       = 1'b0;
    bus.pend_set_en = 1'b0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [15:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_data = data;
  endtask

  task automatic pset(input logic [2:0] sel);
    bus.pend_set_en = 1'b1;
    bus.pend_sel    = sel;
  endtask

  initial begin
    bus.rd1_sel = 3'd0; bus.rd2_sel = 3'd0; bus.wr_sel = 3'd0;
    bus.wr_data = 16'h0; bus.pend_sel = 3'd0;
    idle();
    step(); step();
    rst = 1'b0;
    settle();
    check("reset_rd1", bus.rd1_data, 16'h0000);
    check("reset_pend", 16'(bus.rd1_pend), 16'h0);
    check("reset_err", 16'(bus.err), 16'h0);

    // Asynchronous reset between edges
    step(); wr(3'd3, 16'hBEEF); pset(3'd3);
    step(); idle(); bus.rd1_sel = 3'd3;
    settle();
    check("pre_rst_r3", bus.rd1_data, 16'hBEEF);
    check("pre_rst_pend", 16'(bus.rd1_pend), 16'h1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_r3", bus.rd1_data, 16'h0000);
    check("async_rst_pend", 16'(bus.rd1_pend), 16'h0);
    step(); wr(3'd3, 16'h1111);
    step(); idle(); rst = 1'b0;
    settle();
    check("rst_discard_wr", bus.rd1_data, 16'h0000);

    // Write then read, neighbour untouched
    step(); wr(3'd5, 16'h1234);
    step(); idle(); bus.rd1_sel = 3'd5; bus.rd2_sel = 3'd4;
    settle();
    check("wr_r5", bus.rd1_data, 16'h1234);
    check("wr_r4_clean", bus.rd2_data, 16'h0000);

    // Dual-port bypass
    step(); wr(3'd2, 16'h00FF);
    step(); wr(3'd2, 16'hA5A5); bus.rd1_sel = 3'd2; bus.rd2_sel = 3'd2;
    settle();
    check("byp_rd1", bus.rd1_data, 16'hA5A5);
    check("byp_rd2", bus.rd2_data, 16'hA5A5);
    step(); idle();
    settle();
    check("post_byp_rd1", bus.rd1_data, 16'hA5A5);

    // RAW scoreboard
    step(); pset(3'd6);
    step(); idle(); bus.rd1_sel = 3'd6;
    settle();
    check("raw_pend", 16'(bus.rd1_pend), 16'h1);
    step(); wr(3'd6, 16'h0042);
    settle();
    check("raw_byp_pend", 16'(bus.rd1_pend), 16'h0);
    check("raw_byp_data", bus.rd1_data, 16'h0042);
    step(); idle();
    settle();
    check("raw_cleared", 16'(bus.rd1_pend), 16'h0);

    // Set/clear collision on the same register
    step(); pset(3'd1);
    step(); wr(3'd1, 16'h7777); pset(3'd1); bus.rd2_sel = 3'd1;
    step(); idle();
    settle();
    check("coll_pend", 16'(bus.rd2_pend), 16'h1);
    check("coll_err", 16'(bus.err), 16'h0);

    // Independent set/clear on different registers
    step(); wr(3'd1, 16'h0001); pset(3'd0); bus.rd1_sel = 3'd0;
    step(); idle();
    settle();
    check("indep_r0_pend", 16'(bus.rd1_pend), 16'h1);
    check("indep_r1_pend", 16'(bus.rd2_pend), 16'h0);

    // WAW double producer
    step(); pset(3'd7);
    step(); pset(3'd7);
    step(); idle();
    settle();
    check("waw_err", 16'(bus.err), 16'h1);

    // Further traffic with idle garbage selects; err must stick
    for (int i = 0; i < 8; i++) begin
      step(); wr(3'(i), 16'(16'h1000 + i * 16'h0111));
      step(); idle(); bus.wr_sel = 3'(7 - i); bus.pend_sel = 3'(i);
      bus.wr_data = 16'hDEAD; bus.rd1_sel = 3'(i); bus.rd2_sel = 3'(7 - i);
    end
    settle();
    check("waw_sticky", 16'(bus.err), 16'h1);
    check("traffic_r7", bus.rd1_data, 16'h1777);

    step(); rst = 1'b1;
    settle();
    check("err_cleared", 16'(bus.err), 16'h0);
    step(); rst = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_bypass_sb.md
Name: rf_bypass_sb

Overview:
- Eight-entry, 16-bit general-purpose register file for the processor datapath, with two read ports and one write port.
- Each entry is a 16-bit enabled register. This block generates each register's data input and enable, and it muxes the register states onto the read ports.
- Adds write-to-read bypass and a per-register pending scoreboard so the decode stage can detect RAW hazards on in-flight producers.
- Sits between writeback (write port) and decode (read ports, pending flags).

Parameters:
- WIDTH, 16, data width of each register.
- NREGS, 8, number of registers.
- SEL_W, 3, register select width; must equal log2(NREGS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd1_sel  in  SEL_W  read port 1 register select.
- rd2_sel  in  SEL_W  read port 2 register select.
- wr_sel  in  SEL_W  write port register select.
- wr_data  in  WIDTH  write data.
- wr_en  in  1  write enable.
- pend_set_en  in  1  mark register pend_sel as awaiting a producer.
- pend_sel  in  SEL_W  register to mark pending.
- rd1_data  out  WIDTH  read port 1 data.
- rd2_data  out  WIDTH  read port 2 data.
- rd1_pend  out  1  read port 1 register has an outstanding producer.
- rd2_pend  out  1  read port 2 register has an outstanding producer.
- err  out  1  sticky error flag.

Behaviour:
- Reset:
  - rst high clears all registers, all pending bits and err to 0 immediately, independent of clk.
  - Outputs then read 0 and pending flags read 0.
  - Reset asserted mid-operation discards any same-cycle write or pending set.
- Write:
  - On a rising clk with wr_en=1 and rst=0, register[wr_sel] <= wr_data.
  - Only the selected register's enable is asserted; all others hold.
  - Every register, including R0, is writable; there is no hardwired zero.
- Read:
  - Combinational, zero-cycle latency.
  - rdN_data = register[rdN_sel], except under the bypass rule below.
- Bypass:
  - If wr_en=1 and wr_sel==rdN_sel, rdN_data = wr_data in the same cycle.
  - Applies independently to each port; both ports may bypass simultaneously.
- Pending scoreboard (one bit per register):
  - Set: rising edge with pend_set_en=1 sets pend[pend_sel].
  - Clear: rising edge with wr_en=1 clears pend[wr_sel].
  - Simultaneous set and clear of the same register: set wins and the bit stays 1 (new producer issued as the old one retires).
  - Set and clear of different registers apply independently.
- Pending flags:
  - rdN_pend = pend[rdN_sel] AND NOT (wr_en AND wr_sel==rdN_sel).
  - A value arriving via bypass is not reported as pending.
- err:
  - Set on a rising edge when pend_set_en=1, pend[pend_sel]=1 already, and that bit is not being cleared by the same-cycle write. This flags a double producer / WAW.
  - Sticky until rst.
  - Does not block the set or any write.
- Width:
  - No arithmetic; data passes through unmodified.
  - X/Z on a select while its enable is 0 must not corrupt state.

Test Plan:
- Reset then read: assert rst mid-cycle after writing R3=0xBEEF -> rd1_sel=3 reads 0x0000 without waiting for a clock edge; all pend=0; err=0.
- Write then read: write R5=0x1234 in cycle 0, rd1_sel=5 in cycle 1 -> rd1_data=0x1234. rd2_sel=4 -> 0x0000, no neighbouring register disturbed.
- Bypass: R2 holds 0x00FF; in the same cycle wr_en=1, wr_sel=2, wr_data=0xA5A5, rd1_sel=rd2_sel=2 -> both ports read 0xA5A5 before the edge, and 0xA5A5 after it.
- Scoreboard RAW:
  - pend_set R6, then rd1_sel=6 -> rd1_pend=1.
  - Writeback R6=0x0042 -> rd1_pend=0 during that cycle (bypass), and pend[6]=0 after the edge.
- Set/clear collision: pend[1]=1; same cycle wr_en wr_sel=1 and pend_set_en pend_sel=1 -> pend[1] stays 1 after the edge; err stays 0.
- WAW error: pend[7]=1; pend_set_en pend_sel=7 with no write to R7 -> err=1 after the edge and remains 1 through further traffic until rst.
